spi_master_multi: RTL and testbench

Parametrised, full-duplex SPI master. Successor to the single-device, receive-only thermocouple SPI reader.
- Supports configurable frame width, up to NUM_CS chip selects, all four SPI modes and a MOSI transmit path.
- Sits between the data-logger control FSM and multiple SPI sensors/peripherals on one shared SCLK/MOSI/MISO bus.

---
 rtl/spi_master_multi.sv | 199 +++++++++++++++++++
 tb/tb_spi_master_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: configurable frame width, NUM_CS chip selects, all four SPI modes.
// Optional SPI_LOOPBACK_EN adds a loopback input that samples mosi in place of the miso pin.
module spi_master_multi #(
    parameter int CLK_DIV = 100,
    parameter int DATA_W  = 16,
    parameter int NUM_CS  = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [NUM_CS-1:0] cs_n
);

    localparam int HALF   = CLK_DIV / 2;
    localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [CS_W-1:0]   cs_q, cs_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              busy_q, busy_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    logic do_edge;
    logic leading;
    logic sample_now;
    logic div_wrap;
    logic cs_valid;
    logic rx_bit;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : miso;
`else
    assign rx_bit = miso;
`endif

    assign div_wrap = (div_q == DIV_W'(HALF - 1));
    assign cs_valid = ({1'b0, cs_sel} < (CS_W + 1)'(NUM_CS));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        cs_d       = cs_q;
        mode_d     = mode_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        dout_d     = dout_q;
        dv_d       = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        do_edge    = 1'b0;
        leading    = 1'b0;
        sample_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = mode_q[1];
                if (start && cs_valid) begin
                    state_d = S_SETUP;
                    cs_d    = cs_sel;
                    mode_d  = mode;
                    tx_d    = din;
                    div_d   = '0;
                    edge_d  = '0;
                    sclk_d  = mode[1];
                    if (!mode[0]) begin
                        mosi_d = din[DATA_W-1];
                    end
                end
            end
            S_SETUP: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    state_d = S_XFER;
                    do_edge = 1'b1;
                end
            end
            S_XFER: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    if (edge_q == EDGE_W'(2 * DATA_W)) begin
                        state_d = S_HOLD;
                    end else begin
                        do_edge = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    state_d = S_GAP;
                    dout_d  = rx_q;
                    dv_d    = 1'b1;
                end
            end
            S_GAP: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Even edge indices are leading edges; CPHA picks which kind samples and which drives.
        if (do_edge) begin
            edge_d     = edge_q + EDGE_W'(1);
            sclk_d     = ~sclk_q;
            leading    = ~edge_q[0];
            sample_now = leading ^ mode_q[0];
            if (sample_now) begin
                rx_d = {rx_q[DATA_W-2:0], rx_bit};
            end else if (mode_q[0]) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end else if (edge_q != EDGE_W'(2 * DATA_W - 1)) begin
                mosi_d = tx_q[DATA_W-2];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
        end

        busy_d = (state_d != S_IDLE);
        if ((state_d == S_SETUP) || (state_d == S_XFER) || (state_d == S_HOLD)) begin
            cs_n_d = ~(NUM_CS'(1) << cs_d);
        end else begin
            cs_n_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            cs_q    <= '0;
            mode_q  <= 2'b00;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            cs_q    <= cs_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    // Shift registers are pure datapath and are always reloaded before use.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = busy_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: default instance with a mode-aware slave model,
// plus a small 8-bit instance with mosi wired back to miso (or loopback under SPI_LOOPBACK_EN).
`timescale 1ns/1ps
module tb_spi_master_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  cs_sel = 2'd0;
    logic [1:0]  mode   = 2'd0;
    logic [15:0] din    = 16'd0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso   = 1'b0;
    logic [3:0]  cs_n;

    logic        start2  = 1'b0;
    logic [1:0]  cs_sel2 = 2'd0;
    logic [1:0]  mode2   = 2'd0;
    logic [7:0]  din2    = 8'd0;
    logic [7:0]  dout2;
    logic        dv2;
    logic        busy2;
    logic        sclk2;
    logic        mosi2;
    logic        miso2;
    logic [2:0]  cs_n2;

    int total = 0;
    int bad   = 0;

    spi_master_multi #(.CLK_DIV(100), .DATA_W(16), .NUM_CS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cs_sel(cs_sel), .mode(mode), .din(din),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso),
`ifdef SPI_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .cs_n(cs_n)
    );

`ifdef SPI_LOOPBACK_EN
    logic lb2 = 1'b1;
    assign miso2 = 1'b0;
`else
    assign miso2 = mosi2;
`endif

    spi_master_multi #(.CLK_DIV(4), .DATA_W(8), .NUM_CS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cs_sel(cs_sel2), .mode(mode2), .din(din2),
        .dout(dout2), .dout_valid(dv2), .busy(busy2), .sclk(sclk2), .mosi(mosi2),
        .miso(miso2),
`ifdef SPI_LOOPBACK_EN
        .loopback(lb2),
`endif
        .cs_n(cs_n2)
    );

    // Activity counters sampled on the falling edge.
    int cb[4]   = '{0, 0, 0, 0};
    int cb_s[4] = '{0, 0, 0, 0};
    int busy_cnt = 0, dv_cnt = 0;
    int busy2_cnt = 0, cs2_cnt = 0, dv2_cnt = 0, sclk2_edges = 0;
    logic sclk2_prev = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (!cs_n[i]) cb[i]++;
        if (busy) busy_cnt++;
        if (dout_valid) dv_cnt++;
        if (busy2) busy2_cnt++;
        if (cs_n2 != 3'b111) cs2_cnt++;
        if (dv2) dv2_cnt++;
        if (sclk2 !== sclk2_prev) sclk2_edges++;
        sclk2_prev = sclk2;
    end

    // Slave model for the default instance.
    logic [1:0]  slv_mode = 2'd0;
    logic [15:0] slv_tx   = 16'd0;
    logic [15:0] s_rx     = 16'd0;
    logic        s_act    = 1'b0;
    logic        s_prev   = 1'b0;
    logic        s_lead;
    int          s_txi = 0, s_nsamp = 0, s_rise = 0;

    always @(negedge clk) begin
        if (cs_n == 4'hF) begin
            s_act = 1'b0;
        end else if (!s_act) begin
            s_act = 1'b1; s_txi = 0; s_rx = 16'd0; s_nsamp = 0; s_rise = 0;
            if (!slv_mode[0]) begin
                miso = slv_tx[15];
                s_txi = 1;
            end
        end else if (sclk != s_prev) begin
            s_lead = (sclk != slv_mode[1]);
            if (sclk) s_rise++;
            if (s_lead ^ slv_mode[0]) begin
                s_rx = {s_rx[14:0], mosi};
                s_nsamp++;
            end else if (s_txi < 16) begin
                miso = slv_tx[15 - s_txi];
                s_txi++;
            end
        end
        s_prev = sclk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cs_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (cb[i] != cb_s[i]);
        return m;
    endfunction

    task automatic snap();
        for (int i = 0; i < 4; i++) cb_s[i] = cb[i];
    endtask

    task automatic kick(input logic [1:0] c, input logic [1:0] m, input logic [15:0] d);
        cs_sel = c; mode = m; din = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_idle2(input string tag, input int lim);
        int n = 0;
        while (busy2 && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy2), 32'd0);
    endtask

    int b0, d0, b2_0, c2_0, dv2_0, e2_0;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dv", 32'(dout_valid), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_cs_n2", 32'(cs_n2), 32'h7);

        // Mode 0, device 2
        slv_mode = 2'd0; slv_tx = 16'hA5C3; snap(); b0 = busy_cnt; d0 = dv_cnt;
        kick(2'd2, 2'd0, 16'h3C5A);
        chk("t1_busy_set", 32'(busy), 32'd1);
        chk("t1_cs_n", 32'(cs_n), 32'hB);
        wait_idle("t1_timeout", 2500);
        chk("t1_slave_rx", 32'(s_rx), 32'h3C5A);
        chk("t1_dout", 32'(dout), 32'hA5C3);
        chk("t1_dv_pulses", 32'(dv_cnt - d0), 32'd1);
        chk("t1_cs_low", 32'(cb[2] - cb_s[2]), 32'd1700);
        chk("t1_cs_mask", 32'(cs_mask()), 32'h4);
        chk("t1_busy_len", 32'(busy_cnt - b0), 32'd1750);

        // Mode 3, device 0
        slv_mode = 2'd3; slv_tx = 16'h0001; snap();
        kick(2'd0, 2'd3, 16'hFFFF);
        chk("t2_sclk_idle", 32'(sclk), 32'd1);
        chk("t2_cs_n", 32'(cs_n), 32'hE);
        wait_idle("t2_timeout", 2500);
        chk("t2_rises", 32'(s_rise), 32'd16);
        chk("t2_samples", 32'(s_nsamp), 32'd16);
        chk("t2_slave_rx", 32'(s_rx), 32'hFFFF);
        chk("t2_dout", 32'(dout), 32'h0001);
        chk("t2_cs_mask", 32'(cs_mask()), 32'h1);
        chk("t2_sclk_after", 32'(sclk), 32'd1);

        // Start while busy is ignored
        slv_mode = 2'd0; slv_tx = 16'h5A0F; snap(); d0 = dv_cnt;
        kick(2'd2, 2'd0, 16'h6E91);
        repeat (199) tick();
        kick(2'd1, 2'd0, 16'h1111);
        wait_idle("t3_timeout", 2500);
        chk("t3_slave_rx", 32'(s_rx), 32'h6E91);
        chk("t3_dout", 32'(dout), 32'h5A0F);
        chk("t3_cs_mask", 32'(cs_mask()), 32'h4);
        chk("t3_dv_pulses", 32'(dv_cnt - d0), 32'd1);

        // Reset mid-transfer, then a fresh transfer
        slv_mode = 2'd2; slv_tx = 16'h1234; d0 = dv_cnt;
        kick(2'd1, 2'd2, 16'hABCD);
        repeat (499) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_cs_n", 32'(cs_n), 32'hF);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_sclk", 32'(sclk), 32'd0);
        chk("t4_dout", 32'(dout), 32'd0);
        repeat (20) tick();
        chk("t4_no_dv", 32'(dv_cnt - d0), 32'd0);
        slv_mode = 2'd1; slv_tx = 16'hF00D; snap();
        kick(2'd3, 2'd1, 16'h0F0F);
        wait_idle("t4_timeout", 2500);
        chk("t4_slave_rx", 32'(s_rx), 32'h0F0F);
        chk("t4_dout", 32'(dout), 32'hF00D);
        chk("t4_cs_mask", 32'(cs_mask()), 32'h8);

        // Out-of-range chip select on the 3-device instance
        b2_0 = busy2_cnt; c2_0 = cs2_cnt; e2_0 = sclk2_edges;
        cs_sel2 = 2'd3; mode2 = 2'd0; din2 = 8'h55; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t5_busy", 32'(busy2), 32'd0);
        repeat (20) tick();
        chk("t5_busy_cnt", 32'(busy2_cnt - b2_0), 32'd0);
        chk("t5_cs_cnt", 32'(cs2_cnt - c2_0), 32'd0);
        chk("t5_sclk_edges", 32'(sclk2_edges - e2_0), 32'd0);

        // 8-bit, CLK_DIV=4, mode 1, data returned through mosi
        b2_0 = busy2_cnt; c2_0 = cs2_cnt; dv2_0 = dv2_cnt;
        cs_sel2 = 2'd2; mode2 = 2'd1; din2 = 8'hC3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t6_cs_n", 32'(cs_n2), 32'h3);
        wait_idle2("t6_timeout", 200);
        chk("t6_dout", 32'(dout2), 32'hC3);
        chk("t6_busy_len", 32'(busy2_cnt - b2_0), 32'd38);
        chk("t6_cs_len", 32'(cs2_cnt - c2_0), 32'd36);
        chk("t6_dv_pulses", 32'(dv2_cnt - dv2_0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
